// File: rtl/cpu_param.sv
// cpu_param: multi-cycle SRM core with configurable width W, optional all-ALU flag update and illegal-instruction trap
module cpu_param #(
  parameter int W = 16,
  parameter bit FLAGS_ALL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s,
  input  logic         load,
  input  logic [15:0]  in,
  output logic [W-1:0] out,
  output logic         N,
  output logic         V,
  output logic         Z,
  output logic         w,
  output logic         ill
);
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_WR_IMM, S_TRAP
  } state_t;
  state_t state_q, state_d;
  logic [15:0]  ir_q;
  logic [W-1:0] a_q, b_q, c_q;
  logic [W-1:0] rf_q [8];
  logic         n_q, v_q, z_q, ill_q;
  logic [2:0]   opc, rn, rd, rm;
  logic [1:0]   op, sh;
  logic         is_movi, is_movr, is_alu, is_add, is_cmp, is_and, is_mvn, legal, flag_wr;
  logic [W-1:0] bsh, sum, dif, res, sximm;
  logic         v_alu;
  assign {opc, op, rn, rd, sh, rm} = ir_q;
  assign is_movi = opc == 3'b110 && op == 2'b10;
  assign is_movr = opc == 3'b110 && op == 2'b00;
  assign is_alu  = opc == 3'b101;
  assign is_add  = is_alu && op == 2'b00;
  assign is_cmp  = is_alu && op == 2'b01;
  assign is_and  = is_alu && op == 2'b10;
  assign is_mvn  = is_alu && op == 2'b11;
  assign legal   = is_movi || is_movr || is_alu;
  assign flag_wr = is_cmp || (FLAGS_ALL && (is_add || is_and || is_mvn));
  assign sximm   = W'(signed'(ir_q[7:0]));
  // shifter on B, then the ALU result and signed overflow for ADD/CMP
  always_comb begin
    bsh = sh == 2'b00 ? b_q :
          sh == 2'b01 ? {b_q[W-2:0], 1'b0} :
          sh == 2'b10 ? {1'b0, b_q[W-1:1]} : {b_q[W-1], b_q[W-1:1]};
    sum = a_q + bsh;
    dif = a_q - bsh;
    res = is_add ? sum : is_cmp ? dif : is_and ? (a_q & bsh) : is_mvn ? ~bsh : bsh;
    v_alu = is_add ? (a_q[W-1] == bsh[W-1]) && (sum[W-1] != a_q[W-1]) :
            is_cmp ? (a_q[W-1] != bsh[W-1]) && (dif[W-1] != a_q[W-1]) : 1'b0;
  end
  // next-state logic; DECODE sees the IR loaded on the edge that left WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
      S_DECODE: state_d = !legal ? S_TRAP : is_movi ? S_WR_IMM : (is_movr || is_mvn) ? S_GET_B : S_GET_A;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_ALU;
      S_ALU:    state_d = is_cmp ? S_WAIT : S_WR_REG;
      default:  state_d = S_WAIT;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    state_q <= reset ? S_WAIT : state_d;
  end
  // datapath registers, register file, flags and sticky trap flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      rf_q  <= '{default: '0};
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      if (state_q == S_WAIT && load) ir_q <= in;
      if (state_q == S_GET_A) a_q <= rf_q[rn];
      if (state_q == S_GET_B) b_q <= rf_q[rm];
      if (state_q == S_ALU && !is_cmp) c_q <= res;
      if (state_q == S_ALU && flag_wr) {n_q, v_q, z_q} <= {res[W-1], v_alu, res == '0};
      if (state_q == S_WR_REG) rf_q[rd] <= c_q;
      if (state_q == S_WR_IMM) rf_q[rn] <= sximm;
      if (state_q == S_DECODE && legal) ill_q <= 1'b0;
      if (state_q == S_TRAP) ill_q <= 1'b1;
    end
  end
  assign out = c_q;
  assign N   = n_q;
  assign V   = v_q;
  assign Z   = z_q;
  assign ill = ill_q;
  assign w   = state_q == S_WAIT;
endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: three cpu_param configurations driven in lockstep against a reference model with a scoreboard
module tb_cpu_param;
  logic        clk = 1'b0, reset = 1'b1, s = 1'b0, load = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out0, out1;
  logic [31:0] out2;
  logic [2:0]  n_o, v_o, z_o, w_o, ill_o;
  int total = 0, bad = 0;
  typedef struct packed {
    logic [31:0] c0, c1, c2;
    logic [2:0]  n, v, z;
    logic        il;
    logic [7:0]  low;
  } exp_t;
  exp_t q[$];
  logic [31:0] rf [3][8];
  logic [31:0] mc [3];
  logic [2:0]  mn, mv, mz;
  logic        mill;
  cpu_param #(.W(16), .FLAGS_ALL(1'b0)) d0 (.clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .out(out0), .N(n_o[0]), .V(v_o[0]), .Z(z_o[0]), .w(w_o[0]), .ill(ill_o[0]));
  cpu_param #(.W(16), .FLAGS_ALL(1'b1)) d1 (.clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .out(out1), .N(n_o[1]), .V(v_o[1]), .Z(z_o[1]), .w(w_o[1]), .ill(ill_o[1]));
  cpu_param #(.W(32), .FLAGS_ALL(1'b0)) d2 (.clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .out(out2), .N(n_o[2]), .V(v_o[2]), .Z(z_o[2]), .w(w_o[2]), .ill(ill_o[2]));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic longint sx(input logic [31:0] v, input int wd);
    return wd == 32 ? longint'($signed(v)) : longint'($signed(v[15:0]));
  endfunction
  function automatic logic [15:0] movi(input logic [2:0] rn, input logic [7:0] imm);
    return {5'b11010, rn, imm};
  endfunction
  function automatic logic [15:0] movr(input logic [2:0] rd, input logic [2:0] rm, input logic [1:0] sh);
    return {5'b11000, 3'b000, rd, sh, rm};
  endfunction
  function automatic logic [15:0] alu(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rd,
                                      input logic [2:0] rm, input logic [1:0] sh);
    return {3'b101, op, rn, rd, sh, rm};
  endfunction
  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) rf[c][i] = '0;
      mc[c] = '0;
    end
    mn = '0; mv = '0; mz = '0; mill = 1'b0;
  endtask
  task automatic model(input logic [15:0] ir, output exp_t e);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic [31:0] m, msb, a, b, bs, r;
    longint t, hi, lo;
    logic vv;
    bit movi_i, movr_i, add_i, cmp_i, and_i, mvn_i, fa;
    int wd;
    {opc, op, rn, rd, sh, rm} = ir;
    movi_i = opc == 3'b110 && op == 2'b10;
    movr_i = opc == 3'b110 && op == 2'b00;
    add_i  = opc == 3'b101 && op == 2'b00;
    cmp_i  = opc == 3'b101 && op == 2'b01;
    and_i  = opc == 3'b101 && op == 2'b10;
    mvn_i  = opc == 3'b101 && op == 2'b11;
    for (int c = 0; c < 3; c++) begin
      wd = c == 2 ? 32 : 16;
      fa = c == 1;
      m = wd == 32 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      msb = 32'h1 << (wd - 1);
      hi = (longint'(1) << (wd - 1)) - 1;
      lo = -(longint'(1) << (wd - 1));
      a = rf[c][rn];
      b = rf[c][rm];
      bs = sh == 2'd0 ? b : sh == 2'd1 ? (b << 1) & m : sh == 2'd2 ? b >> 1 : (b >> 1) | (b & msb);
      vv = 1'b0;
      r = bs;
      if (add_i || cmp_i) begin
        t = add_i ? sx(a, wd) + sx(bs, wd) : sx(a, wd) - sx(bs, wd);
        r = 32'(t) & m;
        vv = t > hi || t < lo;
      end
      if (and_i) r = a & bs;
      if (mvn_i) r = ~bs & m;
      if (movi_i) rf[c][rn] = 32'(longint'($signed(ir[7:0]))) & m;
      if (cmp_i || (fa && (add_i || and_i || mvn_i))) begin
        mn[c] = (r & msb) != 0;
        mz[c] = r == 0;
        mv[c] = vv;
      end
      if (movr_i || add_i || and_i || mvn_i) begin
        mc[c] = r;
        rf[c][rd] = r;
      end
    end
    mill = !(movi_i || movr_i || opc == 3'b101);
    e.c0 = mc[0]; e.c1 = mc[1]; e.c2 = mc[2];
    e.n = mn; e.v = mv; e.z = mz; e.il = mill;
    e.low = movi_i || mill ? 8'd2 : (add_i || and_i) ? 8'd5 : 8'd4;
  endtask
  task automatic run(input logic [15:0] ins, input bit pulse);
    exp_t e;
    int n;
    model(ins, e);
    q.push_back(e);
    @(posedge clk); #1;
    in = ins; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    if (pulse) begin
      in = ~ins; load = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
    end
    n = 0;
    while (!w_o[0] && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      total++; bad++;
      $display("FAIL timeout: w still low after %0d cycles for %h", n, ins);
    end
  endtask
  // monitor: on each return to WAIT, pop the oldest expectation and compare
  int low = 0;
  logic wp = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      low = 0;
      wp = 1'b1;
    end else begin
      if (!w_o[0]) low++;
      else if (!wp) begin
        if (q.size() == 0) chk("unexpected_done", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          chk("out_w16", {16'h0, out0}, e.c0);
          chk("out_w16fa", {16'h0, out1}, e.c1);
          chk("out_w32", out2, e.c2);
          chk("N", {29'h0, n_o}, {29'h0, e.n});
          chk("V", {29'h0, v_o}, {29'h0, e.v});
          chk("Z", {29'h0, z_o}, {29'h0, e.z});
          chk("ill", {29'h0, ill_o}, {29'h0, {3{e.il}}});
          chk("w_all", {29'h0, w_o}, 32'h7);
          chk("w_low_cycles", 32'(low), {24'h0, e.low});
        end
        low = 0;
      end
      wp = w_o[0];
    end
  end
  initial begin
    logic [15:0] r;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_w", {29'h0, w_o}, 32'h7);
    chk("rst_out", {16'h0, out0} | {16'h0, out1} | out2, 32'h0);
    chk("rst_flags", {20'h0, n_o, v_o, z_o, ill_o}, 32'h0);
    run(movi(3'd4, 8'hFF), 0);
    run(movi(3'd3, 8'd19), 0);
    run(alu(2'b00, 3'd3, 3'd2, 3'd4, 2'b00), 0);
    run(movr(3'd4, 3'd4, 2'b00), 0);
    run(movi(3'd3, 8'd127), 0);
    run(movi(3'd7, 8'h81), 0);
    run(alu(2'b01, 3'd3, 3'd0, 3'd7, 2'b00), 0);
    run(alu(2'b01, 3'd3, 3'd0, 3'd3, 2'b00), 0);
    run(movi(3'd1, 8'h80), 0);
    run(movr(3'd2, 3'd1, 2'b11), 0);
    run(alu(2'b11, 3'd0, 3'd4, 3'd2, 2'b10), 0);
    run(movr(3'd1, 3'd1, 2'b00), 0);
    run(movi(3'd0, 8'd0), 0);
    run(alu(2'b10, 3'd0, 3'd5, 3'd0, 2'b00), 0);
    run(movi(3'd1, 8'd64), 0);
    for (int i = 0; i < 8; i++) run(alu(2'b00, 3'd1, 3'd1, 3'd1, 2'b00), 0);
    run(alu(2'b00, 3'd1, 3'd6, 3'd1, 2'b00), 0);
    run(16'hE000, 0);
    run(movi(3'd0, 8'd5), 0);
    run(movr(3'd0, 3'd0, 2'b00), 0);
    run(alu(2'b00, 3'd3, 3'd2, 3'd0, 2'b01), 1);
    run(16'hE000, 1);
    run(movi(3'd2, 8'h7E), 1);
    @(posedge clk); #1;
    in = alu(2'b00, 3'd1, 3'd6, 3'd1, 2'b00); load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("midrst_w", {29'h0, w_o}, 32'h7);
    chk("midrst_out", {16'h0, out0} | {16'h0, out1} | out2, 32'h0);
    chk("midrst_flags", {20'h0, n_o, v_o, z_o, ill_o}, 32'h0);
    run(movr(3'd6, 3'd6, 2'b00), 0);
    for (int i = 0; i < 150; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ;
        1: r[15:11] = 5'b11010;
        2: r[15:11] = 5'b11000;
        default: r[15:13] = 3'b101;
      endcase
      run(r, $urandom_range(0, 3) == 0);
    end
    @(posedge clk); @(posedge clk); #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
